// File: rtl/iotdf_gen.sv
`default_nettype none
// ==========================================================================
// iotdf_gen : byte-stream IoT filter (max/min/avg/extract/exclude/peak)
// Revision  : 1.0
// ==========================================================================
module iotdf_gen #(
   parameter int DW  = 128,
   parameter int IW  = 8,
   parameter int GRP = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_en,
   input  logic [IW-1:0] iot_in,
   input  logic [2:0]    fn_sel,
   input  logic [DW-1:0] low,
   input  logic [DW-1:0] high,
   output logic          busy,
   output logic          valid,
   output logic [DW-1:0] iot_out
);
   localparam int BPW = DW / IW;
   localparam int LG  = $clog2(GRP);
   localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [BCW-1:0] BYTE_LAST = BCW'(BPW - 1);
   localparam logic [LG-1:0]  WORD_LAST = LG'(GRP - 1);
   localparam logic [0:0] S_RECV = 1'b0;
   localparam logic [0:0] S_OUT  = 1'b1;

   logic [0:0]     state;
   logic [BCW-1:0] byte_cnt;
   logic [LG-1:0]  word_cnt;
   logic [DW-IW-1:0] shreg;
   logic [2:0]     grp_fn;
   logic [2:0]     mode;
   logic           first;
   logic [DW-1:0]  peak;
   logic [DW-1:0]  run_max;
   logic [DW-1:0]  run_min;
   logic [DW+LG-1:0] sum;

   logic           accept, grp_start, word_done, grp_done, first_word, hit;
   logic [2:0]     fn;
   logic [DW-1:0]  word, new_max, new_min, result;
   logic [DW+LG-1:0] new_sum;

   assign busy       = (state == S_OUT);
   assign accept     = in_en && (state == S_RECV);
   assign grp_start  = accept && (byte_cnt == '0) && (word_cnt == '0);
   assign fn         = grp_start ? fn_sel : grp_fn;
   assign word_done  = accept && (byte_cnt == BYTE_LAST);
   assign grp_done   = word_done && (word_cnt == WORD_LAST);
   assign word       = {shreg, iot_in};
   assign first_word = (word_cnt == '0);

   // Running statistics reload from the first word of every group.
   assign new_max = (first_word || word > run_max) ? word : run_max;
   assign new_min = (first_word || word < run_min) ? word : run_min;
   assign new_sum = first_word ? {{LG{1'b0}}, word} : sum + {{LG{1'b0}}, word};

   always_comb begin
      hit    = 1'b0;
      result = new_max;
      case (fn)
         3'd1: begin hit = grp_done; result = new_max; end
         3'd2: begin hit = grp_done; result = new_min; end
         3'd3: begin hit = grp_done; result = DW'(new_sum >> LG); end
         3'd4: begin hit = word_done && (low < word) && (word < high); result = word; end
         3'd5: begin hit = word_done && ((word < low) || (word > high)); result = word; end
         3'd6: begin hit = grp_done && (first || new_max > peak); result = new_max; end
         3'd7: begin hit = grp_done && (first || new_min < peak); result = new_min; end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_RECV;
         byte_cnt <= '0;
         word_cnt <= '0;
         shreg    <= '0;
         grp_fn   <= '0;
         mode     <= '0;
         first    <= 1'b1;
         peak     <= '0;
         run_max  <= '0;
         run_min  <= '0;
         sum      <= '0;
         valid    <= 1'b0;
         iot_out  <= '0;
      end else begin
         valid <= 1'b0;
         if (state == S_OUT) begin
            state <= S_RECV;
         end else if (accept) begin
            shreg    <= word[DW-IW-1:0];
            byte_cnt <= word_done ? '0 : byte_cnt + 1'b1;
            if (word_done) begin
               word_cnt <= grp_done ? '0 : word_cnt + 1'b1;
               run_max  <= new_max;
               run_min  <= new_min;
               sum      <= new_sum;
            end
            if (hit) begin
               state   <= S_OUT;
               valid   <= 1'b1;
               iot_out <= result;
               if (fn == 3'd6 || fn == 3'd7) begin
                  peak  <= result;
                  first <= 1'b0;
               end
            end
            // A new mode forgets the old peak; the next peak group always reports.
            if (grp_start) begin
               grp_fn <= fn_sel;
               if (fn_sel != mode) begin
                  mode  <= fn_sel;
                  peak  <= '0;
                  first <= 1'b1;
               end
            end
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_iotdf_gen.sv
`default_nettype none
// Scoreboard bench for iotdf_gen: directed groups, expected results queued ahead of the monitor.
module tb_iotdf_gen;
   localparam int DW = 128;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_en = 1'b0;
   logic [7:0]    iot_in = '0;
   logic [2:0]    fn_sel = '0;
   logic [DW-1:0] low = '0;
   logic [DW-1:0] high = '0;
   logic          busy, valid;
   logic [DW-1:0] iot_out;

   int total = 0, bad = 0, cyc = 0, busy_cnt = 0, busy_at = 0, first_cyc = 0;
   bit mark = 1'b0;
   logic [DW-1:0] expq[$];
   logic [DW-1:0] wl[8];

   localparam logic [DW-1:0] ONES  = {DW{1'b1}};
   localparam logic [DW-1:0] LOWV  = {4'h6, {124{1'b1}}};
   localparam logic [DW-1:0] HIGHV = {4'hA, {124{1'b1}}};
   localparam logic [DW-1:0] W7000 = {4'h7, 124'h0};
   localparam logic [DW-1:0] W8000 = {4'h8, 124'h0};
   localparam logic [DW-1:0] WB000 = {4'hB, 124'h0};
   localparam logic [DW-1:0] W6FFE = {4'h6, {123{1'b1}}, 1'b0};
   localparam logic [DW-1:0] AVGX  = {4'hD, {124{1'b1}}};

   iotdf_gen #(.DW(DW), .IW(8), .GRP(8)) dut (
      .clk(clk), .rst(rst), .in_en(in_en), .iot_in(iot_in), .fn_sel(fn_sel),
      .low(low), .high(high), .busy(busy), .valid(valid), .iot_out(iot_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pop one expectation per valid cycle.
   always @(negedge clk) begin
      if (busy) begin
         busy_cnt++;
         if (busy_cnt == 1) busy_at = cyc;
      end
      if (rst && valid) begin
         if (expq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_valid: got %h expected no output", iot_out);
         end else begin
            check("result", iot_out, expq.pop_front());
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int g = 0;
      @(negedge clk);
      while (busy && g < 8) begin
         @(negedge clk);
         g++;
      end
      if (busy) begin
         total++; bad++;
         $display("FAIL busy_timeout: busy=1 expected 0");
      end
      if (mark) begin
         first_cyc = cyc;
         mark = 1'b0;
      end
      in_en  = 1'b1;
      iot_in = b;
   endtask

   task automatic send_word(input logic [DW-1:0] w, input bit gap);
      for (int i = 0; i < 16; i++) begin
         send_byte(w[DW-1-8*i -: 8]);
         if (gap && i == 5) begin
            @(negedge clk);
            in_en = 1'b0;
         end
      end
   endtask

   task automatic send8(input logic [2:0] fn, input bit tog, input logic [2:0] alt, input bit gap);
      fn_sel = fn;
      for (int j = 0; j < 8; j++) begin
         if (tog && j == 3) fn_sel = alt;
         send_word(wl[j], gap && j == 4);
      end
   endtask

   task automatic send_peak(input logic [2:0] fn, input logic [DW-1:0] v, input logic [DW-1:0] fill);
      for (int j = 0; j < 8; j++) wl[j] = (j == 5) ? v : fill;
      send8(fn, 1'b0, 3'd0, 1'b0);
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      in_en = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      @(negedge clk);
      check("reset_busy", DW'(busy), '0);
      check("reset_valid", DW'(valid), '0);
      check("reset_out", iot_out, '0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // T1: max of 1..8, busy exactly one cycle at clock 129
      for (int j = 0; j < 8; j++) wl[j] = DW'(j + 1);
      expq.push_back(DW'(8));
      busy_cnt = 0;
      mark = 1'b1;
      send8(3'd1, 1'b0, 3'd0, 1'b0);
      idle(3);
      check("t1_busy_cycles", DW'(busy_cnt), DW'(1));
      check("t1_busy_clock", DW'(busy_at - first_cyc + 1), DW'(129));

      // T2: average without overflow
      for (int j = 0; j < 8; j++) wl[j] = (j == 7) ? DW'(1) : ONES;
      expq.push_back(AVGX);
      send8(3'd3, 1'b0, 3'd0, 1'b0);

      // T3: extract / exclude with strict bounds
      low = LOWV; high = HIGHV;
      wl = '{LOWV, W7000, HIGHV, '0, ONES, W8000, DW'(1), LOWV};
      expq.push_back(W7000);
      expq.push_back(W8000);
      send8(3'd4, 1'b0, 3'd0, 1'b0);
      wl = '{'0, LOWV, W7000, ONES, HIGHV, W6FFE, W8000, WB000};
      expq.push_back('0);
      expq.push_back(ONES);
      expq.push_back(W6FFE);
      expq.push_back(WB000);
      send8(3'd5, 1'b0, 3'd0, 1'b0);

      // T4: peak max 5,3,5,9 -> 5,9 ; peak min 4,4,2 -> 4,2
      expq.push_back(DW'(5));
      expq.push_back(DW'(9));
      send_peak(3'd6, DW'(5), DW'(1));
      send_peak(3'd6, DW'(3), DW'(1));
      send_peak(3'd6, DW'(5), DW'(1));
      send_peak(3'd6, DW'(9), DW'(1));
      expq.push_back(DW'(4));
      expq.push_back(DW'(2));
      send_peak(3'd7, DW'(4), DW'(100));
      send_peak(3'd7, DW'(4), DW'(100));
      send_peak(3'd7, DW'(2), DW'(100));

      // T5: switch 6->1->6 clears peak; mid-group toggle ignored
      expq.push_back(DW'(7));
      send_peak(3'd6, DW'(7), DW'(1));
      expq.push_back(DW'(3));
      send_peak(3'd1, DW'(3), DW'(1));
      expq.push_back(DW'(2));
      for (int j = 0; j < 8; j++) wl[j] = (j == 5) ? DW'(2) : DW'(1);
      send8(3'd6, 1'b1, 3'd2, 1'b0);
      send_peak(3'd6, DW'(1), DW'(1));
      send_peak(3'd6, DW'(2), DW'(1));
      expq.push_back(DW'(3));
      send_peak(3'd6, DW'(3), DW'(1));

      // reserved function never reports
      send_peak(3'd0, DW'(77), DW'(5));

      // T6: reset after byte 7 of word 3, then a fresh min group
      fn_sel = 3'd2;
      send_word('0, 1'b0);
      send_word('0, 1'b0);
      for (int i = 0; i < 7; i++) send_byte(8'h00);
      @(negedge clk);
      in_en = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check("t6_reset_valid", DW'(valid), '0);
      check("t6_reset_busy", DW'(busy), '0);
      check("t6_reset_out", iot_out, '0);
      @(negedge clk);
      rst = 1'b1;
      for (int j = 0; j < 8; j++) wl[j] = DW'(50 + ((j * 3 + 1) % 8));
      expq.push_back(DW'(50));
      send8(3'd2, 1'b0, 3'd0, 1'b1);

      idle(5);
      check("queue_drained", DW'(expq.size()), '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
